isp_remosaic: RTL and testbench
===============================

Name: isp_remosaic

Overview:
- Converts a streaming RGB pixel stream (pclk/href/vsync timing) back into a single-channel Bayer RAW stream.
- Used to feed RGB test patterns or processed frames into RAW-domain ISP stages, and as the closed-loop partner of the demosaic block in verification (RGB -> RAW -> RGB).
- Also checks incoming line and frame geometry against WIDTH/HEIGHT and flags violations.

Parameters:
- BITS, 8, pixel bit depth per channel.
- WIDTH, 1280, expected active pixels per line (href-high cycles).
- HEIGHT, 960, expected lines per frame.
- BAYER, 0, output CFA order: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.

Ports:
- pclk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- in_href  in  1  line valid; one pixel per pclk while high.
- in_vsync  in  1  frame sync, active high, outside href.
- in_r  in  BITS  red sample.
- in_g  in  BITS  green sample.
- in_b  in  BITS  blue sample.
- out_href  out  1  in_href delayed 2 cycles.
- out_vsync  out  1  in_vsync delayed 2 cycles.
- out_raw  out  BITS  Bayer sample; 0 when out_href low.
- line_len_err  out  1  1-cycle pulse: finished line length != WIDTH.
- frame_len_err  out  1  1-cycle pulse: finished frame line count != HEIGHT.

Behaviour:
- Reset is asynchronous on rst_n, active-low; clock is pclk. All registers clear to 0; every output is 0 during reset.
- pix_odd:
  - Forced 0 while in_href is low.
  - Toggles every cycle in_href is high.
  - The first pixel of each line therefore sees pix_odd = 0.
- line_odd:
  - Forced 0 while in_vsync is high.
  - Toggles on each href falling edge, detected as a registered prev_href of 1 with in_href of 0.
  - The first line after vsync therefore sees line_odd = 0.
- fmt = BAYER[1:0] XOR {line_odd, pix_odd}. fmt 0 selects in_r; fmt 1 or 2 selects in_g; fmt 3 selects in_b.
- Pipeline:
  - Stage 1 registers the selected sample and href.
  - Stage 2 registers out_raw = stage-1 href ? sample : 0.
  - Latency is exactly 2 pclk for data, href and vsync. No backpressure.
- pix_cnt:
  - 16-bit counter, cleared on the cycle after an href falling edge.
  - Increments on each href-high cycle and saturates at 0xFFFF.
- Line check: on an href falling edge, if pix_cnt != WIDTH, assert line_len_err for 1 cycle, 1 cycle after the edge.
- line_cnt:
  - 16-bit counter, saturating.
  - Increments on each href falling edge.
  - Cleared on the cycle after a vsync rising edge.
- Frame check:
  - On a vsync rising edge, if frame_seen = 1 and line_cnt != HEIGHT, assert frame_len_err for 1 cycle.
  - frame_seen sets on the first vsync rising edge after reset, so the partial first frame is never flagged.
- Simultaneous events:
  - An href falling edge and a vsync rising edge in the same cycle count that line before the frame comparison, i.e. the comparison uses line_cnt + 1.
- Geometry checks are status only. Data and timing pass through unchanged regardless of errors.
- A href pulse of 1 cycle is a legal 1-pixel line: pixel is fmt with pix_odd = 0, and line_len_err fires unless WIDTH = 1.
- rst_n asserted mid-line kills in-flight pipeline data immediately, with outputs 0. After release, behaviour is as after power-up, with frame_seen = 0.

Test Plan:
- BAYER=0, WIDTH=4, HEIGHT=2; vsync pulse, then 2 lines of R=0x11, G=0x22, B=0x33 -> out_raw line 0: 11,22,11,22; line 1: 22,33,22,33. out_href equals in_href delayed exactly 2 cycles.
- Same stimulus with BAYER=3 -> line 0: 33,22,33,22; line 1: 22,11,22,11. Repeat for BAYER=1 and BAYER=2 with the expected orders.
- WIDTH=4; drive a 3-pixel line -> line_len_err high for exactly 1 cycle, 1 cycle after the href fall. A 4-pixel line produces no pulse.
- HEIGHT=2; frames of 2, 3 and 2 lines, each bounded by vsync -> no flag at the first vsync after reset; flag only at the vsync closing the 3-line frame.
- Assert rst_n low mid-line after 2 pixels, release, then send a full frame -> all outputs 0 during reset; the next frame is remosaiced correctly from pix_odd = 0, line_odd = 0; no spurious error pulses.
- Loopback: a gradient RGB frame through isp_remosaic then isp_demosaic, same BAYER -> demosaic output on flat-colour regions equals the input RGB exactly.

Source files
------------

// File: rtl/isp_remosaic.sv
// isp_remosaic: turns a streaming RGB pixel stream back into a single-channel
// Bayer RAW stream. It also checks line length (WIDTH) and frame height
// (HEIGHT) and reports violations as 1-cycle pulses.
//
// Ports:
//   pclk, rst_n          pixel clock, asynchronous active-low reset
//   in_href, in_vsync    input line valid / frame sync
//   in_r, in_g, in_b     input RGB sample (BITS each)
//   out_href, out_vsync  timing delayed by 2 pclk
//   out_raw              Bayer sample, 0 while out_href is low
//   line_len_err         pulse: the finished line had pix count != WIDTH
//   frame_len_err        pulse: the finished frame had line count != HEIGHT
module isp_remosaic #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int BAYER  = 0
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_r,
    input  logic [BITS-1:0] in_g,
    input  logic [BITS-1:0] in_b,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_raw,
    output logic            line_len_err,
    output logic            frame_len_err
);

    localparam logic [1:0]  CFA      = 2'(BAYER);
    localparam logic [15:0] WIDTH_C  = 16'(WIDTH);
    localparam logic [15:0] HEIGHT_C = 16'(HEIGHT);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    logic            pix_odd_q, pix_odd_d;
    logic            line_odd_q, line_odd_d;
    logic            prev_href_q, prev_vsync_q;
    logic [BITS-1:0] s1_sample_q, s1_sample_d;
    logic            s1_href_q, s1_vsync_q;
    logic [BITS-1:0] raw_q, raw_d;
    logic            href_q, vsync_q;
    logic [15:0]     pix_cnt_q, pix_cnt_d;
    logic [15:0]     line_cnt_q, line_cnt_d;
    logic [15:0]     line_cnt_inc, lines_at_rise;
    logic            frame_seen_q, frame_seen_d;
    logic            line_err_q, line_err_d;
    logic            frame_err_q, frame_err_d;
    logic            href_fall, vsync_rise;
    logic [1:0]      fmt;

    always_comb begin
        href_fall  = prev_href_q & ~in_href;
        vsync_rise = in_vsync & ~prev_vsync_q;

        // CFA position of the current pixel, remapped by the output order.
        fmt = CFA ^ {line_odd_q, pix_odd_q};
        case (fmt)
            2'd0:    s1_sample_d = in_r;
            2'd3:    s1_sample_d = in_b;
            default: s1_sample_d = in_g;
        endcase

        pix_odd_d  = in_href ? ~pix_odd_q : 1'b0;
        line_odd_d = line_odd_q;
        if (in_vsync)       line_odd_d = 1'b0;
        else if (href_fall) line_odd_d = ~line_odd_q;

        raw_d = s1_href_q ? s1_sample_q : '0;

        pix_cnt_d = pix_cnt_q;
        if (href_fall)                           pix_cnt_d = '0;
        else if (in_href && pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 16'd1;

        line_cnt_inc = (line_cnt_q != CNT_MAX) ? line_cnt_q + 16'd1 : line_cnt_q;
        // A line ending in the same cycle as the vsync rise belongs to the
        // frame being closed, so it is counted before the comparison.
        lines_at_rise = href_fall ? line_cnt_inc : line_cnt_q;

        line_cnt_d = line_cnt_q;
        if (vsync_rise)     line_cnt_d = '0;
        else if (href_fall) line_cnt_d = line_cnt_inc;

        line_err_d   = href_fall && (pix_cnt_q != WIDTH_C);
        // The first frame after reset is partial, so it is never judged.
        frame_err_d  = vsync_rise && frame_seen_q && (lines_at_rise != HEIGHT_C);
        frame_seen_d = frame_seen_q | vsync_rise;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_odd_q    <= 1'b0;
            line_odd_q   <= 1'b0;
            prev_href_q  <= 1'b0;
            prev_vsync_q <= 1'b0;
            s1_sample_q  <= '0;
            s1_href_q    <= 1'b0;
            s1_vsync_q   <= 1'b0;
            raw_q        <= '0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            frame_seen_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            pix_odd_q    <= pix_odd_d;
            line_odd_q   <= line_odd_d;
            prev_href_q  <= in_href;
            prev_vsync_q <= in_vsync;
            s1_sample_q  <= s1_sample_d;
            s1_href_q    <= in_href;
            s1_vsync_q   <= in_vsync;
            raw_q        <= raw_d;
            href_q       <= s1_href_q;
            vsync_q      <= s1_vsync_q;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            frame_seen_q <= frame_seen_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign out_raw       = raw_q;
    assign out_href      = href_q;
    assign out_vsync     = vsync_q;
    assign line_len_err  = line_err_q;
    assign frame_len_err = frame_err_q;

endmodule

// File: tb/tb_isp_remosaic.sv
// Bench for isp_remosaic: four instances (BAYER 0..3, WIDTH=4, HEIGHT=2)
// share one input stream. A directed table covers the CFA orders and the
// geometry pulses; hand sequences and random frames are checked against a
// frame/line/pixel-index model.
module tb_isp_remosaic;

    localparam int W = 4;
    localparam int H = 2;

    logic       pclk, rst_n;
    logic       in_href, in_vsync;
    logic [7:0] in_r, in_g, in_b;
    logic [7:0] raw_o [4];
    logic       href_o [4];
    logic       vs_o [4];
    logic       lerr_o [4];
    logic       ferr_o [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        isp_remosaic #(.BITS(8), .WIDTH(W), .HEIGHT(H), .BAYER(gi)) u_dut (
            .pclk          (pclk),
            .rst_n         (rst_n),
            .in_href       (in_href),
            .in_vsync      (in_vsync),
            .in_r          (in_r),
            .in_g          (in_g),
            .in_b          (in_b),
            .out_href      (href_o[gi]),
            .out_vsync     (vs_o[gi]),
            .out_raw       (raw_o[gi]),
            .line_len_err  (lerr_o[gi]),
            .frame_len_err (ferr_o[gi])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_err = 0;
    int n_lp  = 0;
    int n_fp  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] chan(input int f, input logic [7:0] r, g, b);
        case (f)
            0:       return r;
            3:       return b;
            default: return g;
        endcase
    endfunction

    // Model: position of the current pixel in its line / frame.
    int         m_px, m_ln, m_lines;
    bit         m_ph, m_pv, m_seen;
    logic [7:0] pend_raw [4];
    bit         pend_h, pend_v;

    task automatic model_reset();
        m_px = 0; m_ln = 0; m_lines = 0;
        m_ph = 0; m_pv = 0; m_seen = 0;
        pend_h = 0; pend_v = 0;
        for (int k = 0; k < 4; k++) pend_raw[k] = '0;
    endtask

    task automatic step(input bit h, input bit v, input logic [7:0] r, g, b);
        bit         fall, rise, el, ef;
        int         lines_eff, f;
        logic [7:0] now_raw [4];
        fall      = m_ph && !h;
        rise      = v && !m_pv;
        el        = fall && (m_px != W);
        lines_eff = m_lines + (fall ? 1 : 0);
        ef        = rise && m_seen && (lines_eff != H);
        for (int k = 0; k < 4; k++) begin
            f = k ^ ((m_ln % 2) * 2 + (m_px % 2));
            now_raw[k] = h ? chan(f, r, g, b) : 8'h00;
        end
        in_href = h; in_vsync = v; in_r = r; in_g = g; in_b = b;
        @(posedge pclk); #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("raw[b%0d]", k), 32'(raw_o[k]), 32'(pend_raw[k]));
            chk($sformatf("href[b%0d]", k), 32'(href_o[k]), 32'(pend_h));
            chk($sformatf("vsync[b%0d]", k), 32'(vs_o[k]), 32'(pend_v));
            chk($sformatf("line_err[b%0d]", k), 32'(lerr_o[k]), 32'(el));
            chk($sformatf("frame_err[b%0d]", k), 32'(ferr_o[k]), 32'(ef));
        end
        if (lerr_o[0]) n_lp++;
        if (ferr_o[0]) n_fp++;
        for (int k = 0; k < 4; k++) pend_raw[k] = now_raw[k];
        pend_h = h; pend_v = v;
        m_px    = h ? m_px + 1 : 0;
        m_ln    = v ? 0 : (fall ? m_ln + 1 : m_ln);
        m_lines = rise ? 0 : (fall ? m_lines + 1 : m_lines);
        m_seen  = m_seen | rise;
        m_ph = h; m_pv = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic vs_pulse();
        step(0, 1, 8'h00, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic send_line(input int len, input int gap);
        for (int i = 0; i < len; i++)
            step(1, 0, 8'($urandom), 8'($urandom), 8'($urandom));
        idle(gap);
    endtask

    task automatic check_zero(input string nm);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s[b%0d]", nm, k),
                {27'd0, raw_o[k] != 0, href_o[k], vs_o[k], lerr_o[k], ferr_o[k]}, 32'd0);
    endtask

    // Drives an input mid-stream, pulls reset asynchronously away from the
    // clock edge and checks that every output collapses to 0 at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("rst_async");
        in_href = 0; in_vsync = 0;
        @(posedge pclk); #1 check_zero("rst_hold");
        rst_n = 1'b1;
        model_reset();
        n_lp = 0; n_fp = 0;
    endtask

    typedef struct {
        bit          h, v;
        logic [31:0] raw;   // {bayer3, bayer2, bayer1, bayer0}
        bit          eh, ev, el, ef;
    } vec_t;

    localparam logic [31:0] L0E = 32'h33222211;
    localparam logic [31:0] L0O = 32'h22331122;
    localparam logic [31:0] L1E = 32'h22113322;
    localparam logic [31:0] L1O = 32'h11222233;

    vec_t tbl [21];

    initial begin
        // Outputs after each row's edge reflect the row before it.
        tbl[0]  = '{0, 1, 0,   0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,   0, 1, 0, 0};
        tbl[2]  = '{1, 0, 0,   0, 0, 0, 0};
        tbl[3]  = '{1, 0, L0E, 1, 0, 0, 0};
        tbl[4]  = '{1, 0, L0O, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, L0E, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, L0O, 1, 0, 0, 0};
        tbl[7]  = '{1, 0, 0,   0, 0, 0, 0};
        tbl[8]  = '{1, 0, L1E, 1, 0, 0, 0};
        tbl[9]  = '{1, 0, L1O, 1, 0, 0, 0};
        tbl[10] = '{1, 0, L1E, 1, 0, 0, 0};
        tbl[11] = '{0, 0, L1O, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 0,   0, 0, 0, 0};
        tbl[13] = '{0, 0, 0,   0, 1, 0, 0};
        tbl[14] = '{1, 0, 0,   0, 0, 0, 0};
        tbl[15] = '{1, 0, L0E, 1, 0, 0, 0};
        tbl[16] = '{1, 0, L0O, 1, 0, 0, 0};
        tbl[17] = '{0, 0, L0E, 1, 0, 1, 0};
        tbl[18] = '{0, 0, 0,   0, 0, 0, 0};
        tbl[19] = '{0, 1, 0,   0, 0, 0, 1};
        tbl[20] = '{0, 0, 0,   0, 1, 0, 0};

        rst_n = 1'b0;
        in_href = 0; in_vsync = 0; in_r = 8'h11; in_g = 8'h22; in_b = 8'h33;
        repeat (2) @(posedge pclk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            logic [31:0] rv;
            in_href = tbl[i].h; in_vsync = tbl[i].v;
            @(posedge pclk); #1;
            rv = tbl[i].raw;
            for (int k = 0; k < 4; k++)
                chk($sformatf("tbl%0d raw[b%0d]", i, k), 32'(raw_o[k]), 32'(rv[8*k +: 8]));
            chk($sformatf("tbl%0d href", i), 32'(href_o[0]), 32'(tbl[i].eh));
            chk($sformatf("tbl%0d vsync", i), 32'(vs_o[0]), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d line_err", i), 32'(lerr_o[0]), 32'(tbl[i].el));
            chk($sformatf("tbl%0d frame_err", i), 32'(ferr_o[0]), 32'(tbl[i].ef));
        end

        // Frames of 2, 3 and 2 lines: only the 3-line frame is flagged.
        do_reset();
        vs_pulse();
        for (int l = 0; l < 2; l++) send_line(W, 1);
        vs_pulse();
        for (int l = 0; l < 3; l++) send_line(W, 1);
        vs_pulse();
        for (int l = 0; l < 2; l++) send_line(W, 1);
        vs_pulse();
        chk("frame_pulses_232", 32'(n_fp), 32'd1);
        chk("line_pulses_232", 32'(n_lp), 32'd0);

        // Reset two pixels into a line, then a clean frame.
        vs_pulse();
        step(1, 0, 8'h11, 8'h22, 8'h33);
        step(1, 0, 8'h11, 8'h22, 8'h33);
        do_reset();
        vs_pulse();
        for (int l = 0; l < 2; l++) send_line(W, 2);
        vs_pulse();
        idle(2);
        chk("pulses_after_reset", 32'(n_fp + n_lp), 32'd0);

        // Random geometry including 1-pixel lines and a line ending in the
        // same cycle vsync rises.
        for (int f = 0; f < 12; f++) begin
            int nl;
            vs_pulse();
            idle(int'($urandom_range(0, 2)));
            nl = int'($urandom_range(1, 3));
            for (int l = 0; l < nl; l++)
                send_line(int'($urandom_range(1, 5)),
                          (l == nl - 1) ? int'($urandom_range(0, 1))
                                        : int'($urandom_range(1, 2)));
        end
        vs_pulse();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
